// File: rtl/cfg_frame_pkg.sv
// Shared types and constants for the configuration frame writer.
// Holds the FSM state encoding, header field positions and the default sync word.
package cfg_frame_pkg;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

  // Header word layout: frame index in the low byte, last-frame flag in bit 31.
  localparam int unsigned INDEX_W  = 8;
  localparam int unsigned LAST_BIT = 31;

  typedef enum logic [2:0] {
    SYNC,
    HEADER,
    DATA,
    STROBE,
    HOLD
  } cfg_state_e;

  // States in which a bitstream word can be taken.
  function automatic logic is_ready_state(input cfg_state_e s);
    return (s == SYNC) || (s == HEADER) || (s == DATA);
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Frame index to one-hot latch-enable decoder.
// Indices outside the column produce an all-zero vector.
module frame_strobe_decoder #(
  parameter int unsigned NumFrames = 20,
  parameter int unsigned IndexW    = 8
) (
  input  logic [IndexW-1:0]    i_index,
  input  logic                 i_en,
  output logic [NumFrames-1:0] o_onehot_c
);

  always_comb begin
    o_onehot_c = '0;
    for (int unsigned i = 0; i < NumFrames; i++) begin
      o_onehot_c[i] = i_en && (32'(i_index) == i);
    end
  end

endmodule

// File: rtl/config_frame_writer.sv
// Bitstream-driven configuration frame writer: sync, then header/data pairs,
// each producing a single-cycle one-hot latch strobe followed by a hold cycle.
module config_frame_writer
  import cfg_frame_pkg::*;
#(
  parameter int unsigned                MaxFramesPerCol = 20,
  parameter int unsigned                FrameBitsPerRow = 32,
  parameter logic [FrameBitsPerRow-1:0] SyncWord        = FrameBitsPerRow'(SYNC_WORD_DEFAULT)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [FrameBitsPerRow-1:0] WordIn,
  input  logic                       WordValid,
  output logic                       WordReady,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       Done,
  output logic                       Error
);

  cfg_state_e                 r_state;
  logic [INDEX_W-1:0]         r_index;
  logic                       r_last;
  logic [FrameBitsPerRow-1:0] r_data;
  logic [MaxFramesPerCol-1:0] r_strobe;
  logic                       r_done;
  logic                       r_error;
  logic                       r_ready;

  cfg_state_e                 w_state_next;
  logic [INDEX_W-1:0]         w_index_next;
  logic                       w_last_next;
  logic [FrameBitsPerRow-1:0] w_data_next;
  logic [MaxFramesPerCol-1:0] w_strobe_next;
  logic                       w_done_next;
  logic                       w_error_next;
  logic                       w_ready_next;
  logic                       w_strobe_en;
  logic                       w_accept;
  logic                       w_index_ok;

  assign w_accept   = WordValid && r_ready;
  assign w_index_ok = 32'(WordIn[INDEX_W-1:0]) < MaxFramesPerCol;

  // Strobe is decoded from the captured index and registered on data acceptance.
  frame_strobe_decoder #(
    .NumFrames (MaxFramesPerCol),
    .IndexW    (INDEX_W)
  ) u_strobe_decoder (
    .i_index    (r_index),
    .i_en       (w_strobe_en),
    .o_onehot_c (w_strobe_next)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= SYNC;
      r_index  <= '0;
      r_last   <= 1'b0;
      r_data   <= '0;
      r_strobe <= '0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_index  <= w_index_next;
      r_last   <= w_last_next;
      r_data   <= w_data_next;
      r_strobe <= w_strobe_next;
      r_done   <= w_done_next;
      r_error  <= w_error_next;
      r_ready  <= w_ready_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    w_last_next  = r_last;
    w_data_next  = r_data;
    w_done_next  = r_done;
    w_error_next = r_error;
    w_strobe_en  = 1'b0;

    unique case (r_state)
      SYNC: begin
        if (w_accept && (WordIn == SyncWord)) begin
          w_done_next  = 1'b0;
          w_error_next = 1'b0;
          w_state_next = HEADER;
        end
      end
      HEADER: begin
        if (w_accept) begin
          w_index_next = WordIn[INDEX_W-1:0];
          w_last_next  = WordIn[LAST_BIT];
          if (w_index_ok) begin
            w_state_next = DATA;
          end else begin
            w_error_next = 1'b1;
            w_state_next = SYNC;
          end
        end
      end
      DATA: begin
        if (w_accept) begin
          w_data_next  = WordIn;
          w_strobe_en  = 1'b1;
          w_state_next = STROBE;
        end
      end
      STROBE: begin
        w_state_next = HOLD;
      end
      HOLD: begin
        // Data stays on the latches one more cycle before the next frame.
        if (r_last) begin
          w_done_next  = 1'b1;
          w_state_next = SYNC;
        end else begin
          w_state_next = HEADER;
        end
      end
      default: begin
        w_state_next = SYNC;
      end
    endcase

    w_ready_next = is_ready_state(w_state_next);
  end

  assign WordReady   = r_ready;
  assign FrameData   = r_data;
  assign FrameStrobe = r_strobe;
  assign Done        = r_done;
  assign Error       = r_error;

endmodule

// File: tb/tb_config_frame_writer.sv
// Self-checking bench for config_frame_writer: scenario tasks compare observed
// strobes/data/flags against a word-stream parsing model.
module tb_config_frame_writer;

  localparam int          NF   = 20;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] WordIn = '0;
  logic        WordValid = 1'b0;
  logic        WordReady;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic        Done;
  logic        Error;

  config_frame_writer #(
    .MaxFramesPerCol (NF),
    .FrameBitsPerRow (32),
    .SyncWord        (SYNC)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .WordIn      (WordIn),
    .WordValid   (WordValid),
    .WordReady   (WordReady),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .Done        (Done),
    .Error       (Error)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } frame_t;

  logic [31:0] stim_q[$];
  frame_t      exp_q[$];
  bit          exp_done;
  bit          exp_error;

  logic [19:0] obs_strobe[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  int          acc_cyc[$];
  logic [19:0] ref_strobe[$];
  logic [31:0] ref_data[$];

  int          bad_onehot = 0;
  int          ready_viol = 0;
  int          hold_viol = 0;
  bit          prev_strobe_any = 1'b0;
  logic [31:0] prev_data = '0;

  // Records every strobe cycle and watches ready/data during strobe and hold.
  always @(negedge CLK) begin
    if (FrameStrobe != '0) begin
      obs_strobe.push_back(FrameStrobe);
      obs_data.push_back(FrameData);
      obs_cyc.push_back(cyc);
      if (!$onehot(FrameStrobe)) bad_onehot++;
      if (WordReady) ready_viol++;
    end
    if (prev_strobe_any) begin
      if (WordReady) ready_viol++;
      if (FrameData !== prev_data) hold_viol++;
    end
    prev_strobe_any = (FrameStrobe != '0);
    prev_data       = FrameData;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_obs();
    obs_strobe.delete();
    obs_data.delete();
    obs_cyc.delete();
    bad_onehot      = 0;
    ready_viol      = 0;
    hold_viol       = 0;
    prev_strobe_any = 1'b0;
  endtask

  task automatic do_reset();
    RESET     = 1'b1;
    WordValid = 1'b0;
    WordIn    = '0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    clear_obs();
  endtask

  task automatic settle();
    repeat (6) @(posedge CLK);
    #1;
  endtask

  // Reference: parse the word stream as sync, then (header, data) pairs.
  task automatic model_run();
    bit          in_sess = 1'b0;
    int          i = 0;
    int          idx;
    logic [31:0] w;
    frame_t      f;
    exp_q.delete();
    exp_done  = 1'b0;
    exp_error = 1'b0;
    while (i < stim_q.size()) begin
      w = stim_q[i];
      if (!in_sess) begin
        if (w == SYNC) begin
          in_sess   = 1'b1;
          exp_done  = 1'b0;
          exp_error = 1'b0;
        end
        i++;
      end else begin
        idx = int'(w[7:0]);
        if (idx >= NF) begin
          exp_error = 1'b1;
          in_sess   = 1'b0;
          i++;
        end else if (i + 1 >= stim_q.size()) begin
          i++;
        end else begin
          f.idx  = idx;
          f.data = stim_q[i+1];
          exp_q.push_back(f);
          if (w[31]) begin
            exp_done = 1'b1;
            in_sess  = 1'b0;
          end
          i += 2;
        end
      end
    end
  endtask

  // Offers stim_q in order; a word advances only when taken at a clock edge.
  task automatic drive_stream(input bit rand_valid);
    int i = 0;
    int budget = 0;
    acc_cyc.delete();
    while (i < stim_q.size()) begin
      WordValid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      WordIn    = WordValid ? stim_q[i] : $urandom;
      @(negedge CLK);
      if (WordValid && WordReady) begin
        acc_cyc.push_back(cyc);
        i++;
      end
      @(posedge CLK); #1;
      budget++;
      if (budget > 2000) begin
        n_checks++;
        n_errors++;
        $display("FAIL drive_timeout: accepted %0d of %0d words", i, stim_q.size());
        break;
      end
    end
    WordValid = 1'b0;
    WordIn    = $urandom;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #2;
    n_checks++; if (FrameStrobe !== 20'h0) begin n_errors++; $display("FAIL reset_strobe: got %h want 0", FrameStrobe); end
    n_checks++; if (FrameData !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h want 0", FrameData); end
    n_checks++; if (Done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", Done); end
    n_checks++; if (Error !== 1'b0) begin n_errors++; $display("FAIL reset_error: got %b want 0", Error); end
    do_reset();
    n_checks++; if (WordReady !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", WordReady); end
  endtask

  task automatic test_single_frame();
    do_reset();
    stim_q = '{SYNC, 32'h8000_0003, 32'hDEAD_BEEF};
    model_run();
    drive_stream(1'b0);
    settle();
    n_checks++; if (obs_strobe.size() != 1) begin n_errors++; $display("FAIL single_count: got %0d strobe cycles want 1", obs_strobe.size()); end
    if (obs_strobe.size() >= 1 && acc_cyc.size() == 3) begin
      n_checks++; if (obs_strobe[0] !== 20'h00008) begin n_errors++; $display("FAIL single_strobe: got %h want 00008", obs_strobe[0]); end
      n_checks++; if (obs_data[0] !== exp_q[0].data) begin n_errors++; $display("FAIL single_data: got %h want %h", obs_data[0], exp_q[0].data); end
      n_checks++; if (obs_cyc[0] != acc_cyc[2] + 1) begin n_errors++; $display("FAIL single_latency: strobe cyc %0d want %0d", obs_cyc[0], acc_cyc[2] + 1); end
    end
    n_checks++; if (FrameData !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL single_data_held: got %h want deadbeef", FrameData); end
    n_checks++; if (Done !== 1'b1) begin n_errors++; $display("FAIL single_done: got %b want 1", Done); end
    n_checks++; if (Error !== 1'b0) begin n_errors++; $display("FAIL single_error: got %b want 0", Error); end
    n_checks++; if (hold_viol != 0 || ready_viol != 0) begin n_errors++; $display("FAIL single_hold: hold_viol %0d ready_viol %0d want 0", hold_viol, ready_viol); end
  endtask

  task automatic test_garbage();
    do_reset();
    stim_q = '{32'h1234_5678};
    drive_stream(1'b0);
    n_checks++; if (WordReady !== 1'b1) begin n_errors++; $display("FAIL garbage_ready: got %b want 1", WordReady); end
    settle();
    n_checks++; if (obs_strobe.size() != 0) begin n_errors++; $display("FAIL garbage_strobe: got %0d strobe cycles want 0", obs_strobe.size()); end
    n_checks++; if (Done !== 1'b0 || Error !== 1'b0) begin n_errors++; $display("FAIL garbage_flags: done %b error %b want 0 0", Done, Error); end
    stim_q = '{SYNC, 32'h8000_0001, 32'h0BAD_CAFE};
    drive_stream(1'b0);
    settle();
    n_checks++; if (obs_strobe.size() != 1 || obs_strobe[0] !== 20'h00002) begin n_errors++; $display("FAIL garbage_then_frame: %0d strobes want one of 00002", obs_strobe.size()); end
  endtask

  task automatic test_bad_index();
    do_reset();
    stim_q = '{SYNC, 32'h0000_0014, 32'h8000_0001, 32'h1111_1111};
    model_run();
    drive_stream(1'b0);
    settle();
    n_checks++; if (Error !== 1'b1 || Error !== exp_error) begin n_errors++; $display("FAIL bad_index_error: got %b want 1", Error); end
    n_checks++; if (obs_strobe.size() != exp_q.size()) begin n_errors++; $display("FAIL bad_index_strobe: got %0d strobes want %0d", obs_strobe.size(), exp_q.size()); end
    n_checks++; if (WordReady !== 1'b1 || Done !== 1'b0) begin n_errors++; $display("FAIL bad_index_state: ready %b done %b want 1 0", WordReady, Done); end
    stim_q = '{SYNC};
    drive_stream(1'b0);
    settle();
    n_checks++; if (Error !== 1'b0) begin n_errors++; $display("FAIL bad_index_clear: got %b want 0", Error); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] es;
    do_reset();
    stim_q = '{SYNC, 32'h0000_0000, $urandom, 32'h0000_0013, $urandom, 32'h8000_0005, $urandom};
    model_run();
    drive_stream(1'b0);
    settle();
    n_checks++; if (obs_strobe.size() != 3 || exp_q.size() != 3) begin n_errors++; $display("FAIL b2b_count: got %0d strobes want 3", obs_strobe.size()); end
    if (obs_strobe.size() == 3 && exp_q.size() == 3 && acc_cyc.size() == 7) begin
      for (int k = 0; k < 3; k++) begin
        es = 20'(1) << exp_q[k].idx;
        n_checks++; if (obs_strobe[k] !== es || obs_data[k] !== exp_q[k].data) begin n_errors++; $display("FAIL b2b_frame%0d: got %h/%h want %h/%h", k, obs_strobe[k], obs_data[k], es, exp_q[k].data); end
        n_checks++; if (obs_cyc[k] != acc_cyc[2 + 2 * k] + 1) begin n_errors++; $display("FAIL b2b_latency%0d: strobe cyc %0d want %0d", k, obs_cyc[k], acc_cyc[2 + 2 * k] + 1); end
        if (k > 0) begin
          n_checks++; if (obs_cyc[k] - obs_cyc[k-1] != 4) begin n_errors++; $display("FAIL b2b_spacing%0d: got %0d cycles want 4", k, obs_cyc[k] - obs_cyc[k-1]); end
        end
      end
    end
    n_checks++; if (ready_viol != 0 || hold_viol != 0 || bad_onehot != 0) begin n_errors++; $display("FAIL b2b_monitor: ready %0d hold %0d onehot %0d want 0", ready_viol, hold_viol, bad_onehot); end
    n_checks++; if (Done !== exp_done || Error !== exp_error) begin n_errors++; $display("FAIL b2b_flags: done %b error %b want %b %b", Done, Error, exp_done, exp_error); end
  endtask

  task automatic test_reset_in_strobe();
    do_reset();
    stim_q = '{SYNC, 32'h0000_0002, $urandom};
    drive_stream(1'b0);
    n_checks++; if (FrameStrobe !== 20'h00004) begin n_errors++; $display("FAIL rst_strobe_pre: got %h want 00004", FrameStrobe); end
    RESET = 1'b1;
    #1;
    n_checks++; if (FrameStrobe !== 20'h0 || FrameData !== 32'h0) begin n_errors++; $display("FAIL rst_strobe_async: strobe %h data %h want 0 0", FrameStrobe, FrameData); end
    @(posedge CLK); #1;
    RESET = 1'b0;
    clear_obs();
    stim_q = '{32'h8000_0001, $urandom};
    model_run();
    drive_stream(1'b0);
    settle();
    n_checks++; if (obs_strobe.size() != exp_q.size()) begin n_errors++; $display("FAIL rst_no_resync: got %0d strobes want %0d", obs_strobe.size(), exp_q.size()); end
    n_checks++; if (Done !== 1'b0 || WordReady !== 1'b1) begin n_errors++; $display("FAIL rst_state: done %b ready %b want 0 1", Done, WordReady); end
  endtask

  task automatic test_random_valid();
    logic [19:0] es;
    logic [31:0] g;
    int          i0;
    int          i1;
    i0 = $urandom_range(0, NF - 1);
    i1 = $urandom_range(0, NF - 1);
    stim_q = '{SYNC, 32'(i0), $urandom, 32'h8000_0000 | 32'(i1), $urandom};
    model_run();
    do_reset();
    drive_stream(1'b0);
    settle();
    ref_strobe = obs_strobe;
    ref_data   = obs_data;
    do_reset();
    drive_stream(1'b1);
    settle();
    n_checks++; if (obs_strobe.size() != 2 || ref_strobe.size() != 2) begin n_errors++; $display("FAIL rv_count: got %0d/%0d strobes want 2", obs_strobe.size(), ref_strobe.size()); end
    if (obs_strobe.size() == 2 && ref_strobe.size() == 2) begin
      for (int k = 0; k < 2; k++) begin
        es = 20'(1) << exp_q[k].idx;
        n_checks++; if (obs_strobe[k] !== ref_strobe[k] || obs_data[k] !== ref_data[k] || obs_strobe[k] !== es || obs_data[k] !== exp_q[k].data) begin n_errors++; $display("FAIL rv_frame%0d: got %h/%h want %h/%h", k, obs_strobe[k], obs_data[k], es, exp_q[k].data); end
      end
    end
    n_checks++; if (hold_viol != 0 || ready_viol != 0 || Done !== 1'b1) begin n_errors++; $display("FAIL rv_hold: hold %0d ready %0d done %b want 0 0 1", hold_viol, ready_viol, Done); end

    // Random sessions with garbage prefix, possible bad indices and early last flags.
    for (int s = 0; s < 4; s++) begin
      stim_q.delete();
      g = $urandom;
      if (g == SYNC) g = g ^ 32'h1;
      stim_q.push_back(g);
      stim_q.push_back(SYNC);
      for (int f = 0; f < 3; f++) begin
        stim_q.push_back(((f == 2 || $urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'h0) | 32'($urandom_range(0, NF + 3)));
        stim_q.push_back($urandom);
      end
      model_run();
      do_reset();
      drive_stream(1'b1);
      settle();
      n_checks++; if (obs_strobe.size() != exp_q.size()) begin n_errors++; $display("FAIL rs%0d_count: got %0d strobes want %0d", s, obs_strobe.size(), exp_q.size()); end
      if (obs_strobe.size() == exp_q.size()) begin
        for (int k = 0; k < exp_q.size(); k++) begin
          es = 20'(1) << exp_q[k].idx;
          n_checks++; if (obs_strobe[k] !== es || obs_data[k] !== exp_q[k].data) begin n_errors++; $display("FAIL rs%0d_frame%0d: got %h/%h want %h/%h", s, k, obs_strobe[k], obs_data[k], es, exp_q[k].data); end
        end
      end
      n_checks++; if (Done !== exp_done || Error !== exp_error || bad_onehot != 0) begin n_errors++; $display("FAIL rs%0d_flags: done %b error %b onehot %0d want %b %b 0", s, Done, Error, bad_onehot, exp_done, exp_error); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_garbage();
    test_bad_index();
    test_back_to_back();
    test_reset_in_strobe();
    test_random_valid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
